// File: rtl/p_hit_dispatch_pkg.sv
// Shared types and constants for the hit-point pipeline front end.
// Holds the record vector type, the lane numbering and the dispatcher state encoding.
package p_hit_pkg;

    typedef logic signed [2:0][31:0] vec3_t;

    localparam int LANE_TRI1 = 0;
    localparam int LANE_TRI2 = 1;
    localparam int LANE_DIR2 = 2;
    localparam int LANE_ORG2 = 3;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

endpackage

// File: rtl/p_hit_dispatch_if.sv
// Upstream FWFT FIFO head plus the four downstream lane write ports of p_hit.
// master = the dispatcher, slave = the FIFOs around it.
interface p_hit_dispatch_if;
    import p_hit_pkg::*;

    vec3_t            in_tri_normal;
    vec3_t            in_v0;
    vec3_t            in_origin;
    vec3_t            in_dir;
    logic             in_empty;
    logic             in_rd_en;

    vec3_t            tri_normal_1;
    vec3_t            tri_normal_2;
    vec3_t            v0;
    vec3_t            origin_1;
    vec3_t            origin_2;
    vec3_t            dir_1;
    vec3_t            dir_2;
    logic [3:0]       out_wr_en;
    logic [3:0]       out_full;

    modport master (
        input  in_tri_normal, in_v0, in_origin, in_dir, in_empty, out_full,
        output in_rd_en, tri_normal_1, tri_normal_2, v0, origin_1, origin_2,
               dir_1, dir_2, out_wr_en
    );

    modport slave (
        output in_tri_normal, in_v0, in_origin, in_dir, in_empty, out_full,
        input  in_rd_en, tri_normal_1, tri_normal_2, v0, origin_1, origin_2,
               dir_1, dir_2, out_wr_en
    );

endinterface

// File: rtl/p_hit_dispatch.sv
// Pops one ray/triangle record and writes it once into each of the four p_hit lanes,
// tolerating per-lane backpressure; the next record is popped only once every lane has it.
module p_hit_dispatch
    import p_hit_pkg::*;
#(
    parameter int Q_BITS  = 16,
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    p_hit_dispatch_if.master   bus,
    output logic               busy,
    output logic [COUNT_W-1:0] dispatched
);

    if (Q_BITS < 0 || Q_BITS > 31) begin : g_bad_q_bits
        $error("Q_BITS must fit inside a 32-bit fixed-point word");
    end

    state_t               state;
    state_t               state_nxt;
    logic [NUM_LANES-1:0] done;
    logic [NUM_LANES-1:0] wr_en;
    logic                 all_done;
    logic                 capture;
    vec3_t                hold_normal;
    vec3_t                hold_v0;
    vec3_t                hold_origin;
    vec3_t                hold_dir;

    // A lane is written in its first free cycle and then masked off until the next record.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign wr_en[g] = (state == ISSUE) && !done[g] && !bus.out_full[g];
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        all_done  = (state == ISSUE) && (&(done | wr_en));
        case (state)
            IDLE: begin
                if (!bus.in_empty) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (all_done) begin
                    if (!bus.in_empty) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Back-to-back capture in the completing cycle keeps one record per cycle when unstalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= '0;
            hold_normal <= '0;
            hold_v0     <= '0;
            hold_origin <= '0;
            hold_dir    <= '0;
            dispatched  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_normal <= bus.in_tri_normal;
                hold_v0     <= bus.in_v0;
                hold_origin <= bus.in_origin;
                hold_dir    <= bus.in_dir;
                done        <= '0;
            end else if (state == ISSUE) begin
                done <= done | wr_en;
            end
            if (all_done) begin
                dispatched <= dispatched + COUNT_W'(1);
            end
        end
    end

    assign bus.in_rd_en     = capture;
    assign bus.out_wr_en    = wr_en;
    assign bus.tri_normal_1 = hold_normal;
    assign bus.tri_normal_2 = hold_normal;
    assign bus.v0           = hold_v0;
    assign bus.origin_1     = hold_origin;
    assign bus.origin_2     = hold_origin;
    assign bus.dir_1        = hold_dir;
    assign bus.dir_2        = hold_dir;
    assign busy             = (state == ISSUE);

endmodule

// File: tb/tb_p_hit_dispatch.sv
// Scoreboard bench for p_hit_dispatch: records popped from a modelled upstream FIFO must reach
// every lane exactly once, in order, in each lane's first free cycle.
module tb_p_hit_dispatch;
    import p_hit_pkg::*;

    localparam int COUNT_W = 4;

    typedef struct packed {
        vec3_t n;
        vec3_t v0;
        vec3_t o;
        vec3_t d;
    } rec_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               busy;
    logic [COUNT_W-1:0] dispatched;

    p_hit_dispatch_if bus ();

    p_hit_dispatch #(.Q_BITS(16), .COUNT_W(COUNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .dispatched (dispatched)
    );

    always #5 clock = ~clock;

    rec_t up_q[$];
    rec_t recs[$];
    int   wr_cnt[NUM_LANES];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int completed_cnt();
        int m = wr_cnt[0];
        for (int i = 1; i < NUM_LANES; i++) if (wr_cnt[i] < m) m = wr_cnt[i];
        return m;
    endfunction

    function automatic logic [287:0] lane_exp(input rec_t r, input int lane);
        case (lane)
            LANE_TRI1: return {r.n, r.v0, r.o};
            LANE_TRI2: return 288'({r.n, r.d});
            LANE_DIR2: return 288'(r.d);
            default:   return 288'(r.o);
        endcase
    endfunction

    function automatic logic [287:0] lane_act(input int lane);
        case (lane)
            LANE_TRI1: return {bus.tri_normal_1, bus.v0, bus.origin_1};
            LANE_TRI2: return 288'({bus.tri_normal_2, bus.dir_1});
            LANE_DIR2: return 288'(bus.dir_2);
            default:   return 288'(bus.origin_2);
        endcase
    endfunction

    // Monitor: every lane that still owes a record and is not full must be written now.
    task automatic check_output();
        int   comp;
        logic owed;
        logic exp_wr;
        logic exp_rd;
        comp = completed_cnt();
        check("dispatched", 288'(dispatched), 288'(comp % (1 << COUNT_W)));
        check("busy", 288'(busy), 288'(recs.size() > comp));
        for (int i = 0; i < NUM_LANES; i++) begin
            owed   = wr_cnt[i] < recs.size();
            exp_wr = owed && !bus.out_full[i];
            check($sformatf("out_wr_en[%0d]", i), 288'(bus.out_wr_en[i]), 288'(exp_wr));
            if (bus.out_wr_en[i] && owed) begin
                check($sformatf("lane%0d_data", i), lane_act(i), lane_exp(recs[wr_cnt[i]], i));
                wr_cnt[i]++;
            end
        end
        exp_rd = !bus.in_empty && (recs.size() == completed_cnt());
        check("in_rd_en", 288'(bus.in_rd_en), 288'(exp_rd));
        if (bus.in_rd_en && up_q.size() > 0) recs.push_back(up_q.pop_front());
    endtask

    always @(negedge clock) if (reset) check_output();

    task automatic apply_stimulus(input logic [3:0] full);
        @(posedge clock);
        #1;
        bus.out_full = full;
        bus.in_empty = (up_q.size() == 0);
        if (up_q.size() > 0) begin
            bus.in_tri_normal = up_q[0].n;
            bus.in_v0         = up_q[0].v0;
            bus.in_origin     = up_q[0].o;
            bus.in_dir        = up_q[0].d;
        end
    endtask

    task automatic push_random();
        rec_t r;
        r.n  = {$urandom, $urandom, $urandom};
        r.v0 = {$urandom, $urandom, $urandom};
        r.o  = {$urandom, $urandom, $urandom};
        r.d  = {$urandom, $urandom, $urandom};
        up_q.push_back(r);
    endtask

    task automatic wait_drain(input string name);
        logic drained = 1'b0;
        for (int k = 0; k < 300; k++) begin
            apply_stimulus(4'b0000);
            if (up_q.size() == 0 && completed_cnt() == recs.size()) begin
                drained = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, 288'(drained), 288'(1));
    endtask

    task automatic clear_model();
        up_q.delete();
        recs.delete();
        for (int i = 0; i < NUM_LANES; i++) wr_cnt[i] = 0;
    endtask

    initial begin
        rec_t r;
        int   pushed;
        reset = 1'b0;
        bus.in_empty = 1'b1;
        bus.out_full = 4'b0000;
        bus.in_tri_normal = '0;
        bus.in_v0 = '0;
        bus.in_origin = '0;
        bus.in_dir = '0;
        clear_model();
        #1;
        check("reset_busy", 288'(busy), 288'(0));
        check("reset_dispatched", 288'(dispatched), 288'(0));
        check("reset_rd_en", 288'(bus.in_rd_en), 288'(0));
        check("reset_wr_en", 288'(bus.out_wr_en), 288'(0));
        check("reset_hold", 288'(bus.tri_normal_1), 288'(0));
        #11 reset = 1'b1;

        $display("[TB] single record");
        r.n  = {32'sd0, 32'sd0, 32'sh10000};
        r.v0 = {32'sd0, 32'sd0, 32'sh50000};
        r.o  = '0;
        r.d  = {32'sd0, 32'sd0, 32'sh10000};
        up_q.push_back(r);
        wait_drain("single");
        check("single_dispatched", 288'(dispatched), 288'(1));
        check("single_busy", 288'(busy), 288'(0));

        $display("[TB] eight back-to-back records");
        for (int i = 0; i < 8; i++) push_random();
        wait_drain("b2b");
        check("b2b_dispatched", 288'(dispatched), 288'(9));

        $display("[TB] lane 2 held full for five cycles");
        for (int i = 0; i < 2; i++) push_random();
        for (int i = 0; i < 6; i++) apply_stimulus(4'b0100);
        wait_drain("lane2_stall");
        check("lane2_dispatched", 288'(dispatched), 288'(11));

        $display("[TB] staggered release 3,0,2,1");
        push_random();
        for (int i = 0; i < 3; i++) apply_stimulus(4'b1111);
        apply_stimulus(4'b0111);
        apply_stimulus(4'b0110);
        apply_stimulus(4'b0010);
        apply_stimulus(4'b0000);
        check("stagger_before_lane1", 288'(dispatched), 288'(11));
        apply_stimulus(4'b1111);
        check("stagger_after_lane1", 288'(dispatched), 288'(12));
        wait_drain("stagger");

        $display("[TB] randomized traffic with random backpressure");
        pushed = 0;
        for (int c = 0; c < 200; c++) begin
            if (pushed < 25 && (c >= 100 || $urandom_range(0, 1) == 1)) begin
                push_random();
                pushed++;
            end
            apply_stimulus(4'($urandom & $urandom));
        end
        wait_drain("random");
        check("random_dispatched_wrapped", 288'(dispatched), 288'(5));

        $display("[TB] reset while lane 2 stalled");
        push_random();
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0100);
        #3;
        reset = 1'b0;
        bus.in_empty = 1'b1;
        clear_model();
        #1;
        check("midreset_busy", 288'(busy), 288'(0));
        check("midreset_dispatched", 288'(dispatched), 288'(0));
        check("midreset_wr_en", 288'(bus.out_wr_en), 288'(0));
        check("midreset_rd_en", 288'(bus.in_rd_en), 288'(0));
        check("midreset_dir2", 288'(bus.dir_2), 288'(0));
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(4'b0000);
        check("post_reset_dispatched", 288'(dispatched), 288'(0));
        push_random();
        wait_drain("post_reset");
        check("post_reset_one", 288'(dispatched), 288'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/p_hit_dispatch.md
# p_hit_dispatch

Front-end writer for the hit-point pipeline: consumes one ray/triangle record per transaction from a first-word-fall-through upstream FIFO and fans it out to the four independent input FIFO lanes of `p_hit`. Each lane is written exactly once per record, with per-lane backpressure tolerated. The next record is popped only after all four lanes have accepted the current one, so records stay aligned across lanes.

## Interface
- `Q_BITS`, 16: fixed-point fraction bits; carried for consistency, no arithmetic here.
- `COUNT_W`, 32: width of the dispatched-record counter.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `in_tri_normal`  in  signed 32 x[2:0]  triangle normal, head of upstream FIFO.
- `in_v0`  in  signed 32 x[2:0]  triangle vertex 0.
- `in_origin`  in  signed 32 x[2:0]  ray origin.
- `in_dir`  in  signed 32 x[2:0]  ray direction.
- `in_empty`  in  1  upstream FIFO empty; inputs valid when low.
- `in_rd_en`  out  1  pop upstream; combinational.
- `tri_normal_1`, `tri_normal_2`, `v0`, `origin_1`, `origin_2`, `dir_1`, `dir_2`  out  signed 32 x[2:0]  registered copies of the held record.
- `out_wr_en`  out  1 x[3:0]  per-lane write strobe; combinational.
- `out_full`  in  1 x[3:0]  per-lane full from downstream.
- `busy`  out  1  a record is held.
- `dispatched`  out  COUNT_W  records fully delivered since reset; wraps.

## Operation
- Lane map: lane 0 = {tri_normal_1, v0, origin_1}; lane 1 = {tri_normal_2, dir_1}; lane 2 = {dir_2}; lane 3 = {origin_2}. Both `_1`/`_2` copies come from the same held register.
- State: `IDLE` (no record) / `ISSUE` (record held), plus `done[3:0]` mask.
- `IDLE`: if `!in_empty`, assert `in_rd_en`, capture all inputs into holding register, clear `done`, go `ISSUE`.
- `ISSUE`: `out_wr_en[i] = !done[i] && !out_full[i]`; on that edge set `done[i]`.
- Completion: `all = &(done | out_wr_en)`. When `all`, increment `dispatched`. If `!in_empty` also, pop and capture the next record, clear `done`, stay `ISSUE`. Otherwise go `IDLE`.
- `in_rd_en` is asserted only in the two capture cases above; never when `in_empty`.
- Lanes with `out_full` low are written independently. A full lane only stalls itself, never re-writes already-accepted lanes.
- `busy` = (state == `ISSUE`).
- No data modification; widths pass through 32-bit signed unchanged.

## Timing
- Reset values: state `IDLE`, `done`=0, holding registers 0, `dispatched`=0, `busy`=0.
- Combinational outputs with `in_empty`=1: `in_rd_en`=0, `out_wr_en`=0.
- Latency: record popped at edge N is presented and written on all free lanes in cycle N+1.
- Throughput: one record per cycle with no backpressure (back-to-back pop in the same cycle as the final writes).
- `out_full` is sampled combinationally in the same cycle as `out_wr_en`. A write is never issued to a lane whose full is high.
- All four lanes freeing in different cycles: each is written in its own first free cycle. The record completes in the cycle the last lane is written.
- `dispatched` wraps from 2^COUNT_W−1 to 0.
- Reset asserted mid-`ISSUE`: the held record is discarded (lanes already written keep their data downstream). The bench flushes downstream FIFOs on the same reset.

## Structure
- Shared package `p_hit_pkg`: `vec3_t` (signed [31:0] x[2:0]), lane index constants `LANE_TRI1`, `LANE_TRI2`, `LANE_DIR2`, `LANE_ORG2`, `NUM_LANES`=4, and the state enum.
- Single module; no sub-module needed. Per-lane logic is a generate loop over `NUM_LANES`.

## Test plan
- Single record {normal=(1,0,0)<<16, v0=(5,0,0)<<16, origin=0, dir=(1,0,0)<<16}, all lanes free -> `in_rd_en` one cycle; next cycle `out_wr_en`=4'b1111; all outputs match; `dispatched`=1; `busy` falls.
- 8 back-to-back records, no backpressure -> 8 consecutive cycles of `out_wr_en`=4'b1111; `in_rd_en` high for 8 cycles; `dispatched`=8.
- `out_full`=4'b0100 held 5 cycles, then released -> lanes 0, 1, 3 written in cycle 1; lane 2 written in cycle 6 only; no lane written twice; next pop coincides with the lane-2 write.
- Staggered release: full 4'b1111, then lanes free one per cycle in order 3, 0, 2, 1 -> exactly one `out_wr_en` bit per cycle, in that order; `dispatched` increments only after lane 1.
- Reset asserted while lane 2 is stalled -> all outputs return to reset values asynchronously; after release with `in_empty`=1, nothing is written.
- `COUNT_W`=4, 17 records -> `dispatched` reads 1 after wrap.
